// File: rtl/ieeedrv_pkg.sv
// ieeedrv_pkg: shared state type, command widths and the round-robin search
// helper used by the IEEE drive SD-port arbitration logic.
package ieeedrv_pkg;

  localparam int unsigned LBA_W    = 32;
  localparam int unsigned BLKCNT_W = 6;

  // Round-robin helper works on a fixed-width request vector; callers with
  // fewer requesters zero-extend and pass their real count in n.
  localparam int unsigned RR_MAX   = 8;
  localparam int unsigned RR_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    XFER   = 2'd2,
    FINISH = 2'd3
  } sd_state_t;

  // Returns the first set index of reqvec at or after ptr, wrapping at n.
  // Returns 0 when nothing is requested; callers qualify with |reqvec.
  function automatic logic [RR_IDX_W-1:0] rr_next(
    input logic [RR_IDX_W-1:0] ptr,
    input logic [RR_MAX-1:0]   reqvec,
    input int unsigned         n
  );
    logic [RR_IDX_W:0]   idx;
    logic [RR_IDX_W-1:0] pick;
    logic                found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < RR_MAX; i++) begin
      idx = {1'b0, ptr} + (RR_IDX_W+1)'(i);
      if (idx >= (RR_IDX_W+1)'(n)) begin
        idx = idx - (RR_IDX_W+1)'(n);
      end
      if (!found && (i < n) && reqvec[idx[RR_IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[RR_IDX_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ieeedrv_rr_grant.sv
// ieeedrv_rr_grant: combinational round-robin picker with a registered
// search pointer. The pointer only moves when the caller accepts a grant.
module ieeedrv_rr_grant
  import ieeedrv_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  logic [RR_IDX_W-1:0] ptr_q, ptr_d;
  logic [RR_MAX-1:0]   req_ext;
  logic [RR_IDX_W-1:0] pick;

  // Widen the request vector and pick the first requester at/after ptr.
  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req_i;
    pick           = rr_next(ptr_q, req_ext, N);
  end

  // After an accepted grant the next search starts one past the winner.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && valid_o) begin
      ptr_d = (pick == RR_IDX_W'(N-1)) ? '0 : pick + 1'b1;
    end
  end

  // Search pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign valid_o = |req_i;
  assign idx_o   = pick[IW-1:0];

endmodule

// File: rtl/ieeedrv_sd_arb.sv
// ieeedrv_sd_arb: serialises per-subdrive track read/write requests onto the
// single host SD block port, routes the host ack back to the owner only and
// aborts host transactions that never complete via a watchdog.
module ieeedrv_sd_arb
  import ieeedrv_pkg::*;
#(
  parameter  int unsigned SUBDRV    = 2,
  parameter  int unsigned TIMEOUT_W = 24,
  localparam int unsigned OW        = (SUBDRV > 1) ? $clog2(SUBDRV) : 1
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic [SUBDRV-1:0]          mounted,
  input  logic [LBA_W*SUBDRV-1:0]    req_lba,
  input  logic [BLKCNT_W*SUBDRV-1:0] req_blk_cnt,
  input  logic [SUBDRV-1:0]          req_rd,
  input  logic [SUBDRV-1:0]          req_wr,
  output logic [SUBDRV-1:0]          req_ack,
  output logic [LBA_W-1:0]           sd_lba,
  output logic [BLKCNT_W-1:0]        sd_blk_cnt,
  output logic                       sd_rd,
  output logic                       sd_wr,
  input  logic                       sd_ack,
  output logic [OW-1:0]              owner,
  output logic                       active,
  output logic                       timeout
);

  sd_state_t             state_q, state_d;
  logic [OW-1:0]         owner_q, owner_d;
  logic [LBA_W-1:0]      lba_q, lba_d;
  logic [BLKCNT_W-1:0]   blk_q, blk_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [SUBDRV-1:0]     ack_q, ack_d;
  logic                  active_q, active_d;
  logic                  timeout_q, timeout_d;
  logic                  synth_q, synth_d;
  logic [TIMEOUT_W-1:0]  wd_q, wd_d;

  logic                  gnt_valid;
  logic [OW-1:0]         gnt_idx;
  logic                  gnt_advance;
  logic [LBA_W-1:0]      sel_lba;
  logic [BLKCNT_W-1:0]   sel_blk;
  logic                  sel_wr;
  logic                  sel_mounted;
  logic [SUBDRV-1:0]     gnt_1h;
  logic [SUBDRV-1:0]     own_1h;
  logic                  wd_fire;

  ieeedrv_rr_grant #(
    .N  (SUBDRV),
    .IW (OW)
  ) u_rr (
    .clk_i     (clk_sys),
    .rst_ni    (reset_n),
    .req_i     (req_rd | req_wr),
    .advance_i (gnt_advance),
    .valid_o   (gnt_valid),
    .idx_o     (gnt_idx)
  );

  // Mux the granted subdrive's command and decode grant/owner one-hots.
  always_comb begin
    sel_lba     = '0;
    sel_blk     = '0;
    sel_wr      = 1'b0;
    sel_mounted = 1'b0;
    gnt_1h      = '0;
    own_1h      = '0;
    for (int unsigned d = 0; d < SUBDRV; d++) begin
      if (gnt_idx == OW'(d)) begin
        sel_lba     = req_lba[d*LBA_W +: LBA_W];
        sel_blk     = req_blk_cnt[d*BLKCNT_W +: BLKCNT_W];
        sel_wr      = req_wr[d];
        sel_mounted = mounted[d];
        gnt_1h[d]   = 1'b1;
      end
      if (owner_q == OW'(d)) begin
        own_1h[d] = 1'b1;
      end
    end
  end

  // Next-state and output logic; req_ack is recomputed every cycle so it
  // only ever follows the host ack while a transaction is owned.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lba_d       = lba_q;
    blk_d       = blk_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    ack_d       = '0;
    active_d    = active_q;
    timeout_d   = 1'b0;
    synth_d     = 1'b0;
    gnt_advance = 1'b0;
    wd_fire     = &wd_q;

    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          gnt_advance = 1'b1;
          owner_d     = gnt_idx;
          lba_d       = sel_lba;
          blk_d       = sel_blk;
          active_d    = 1'b1;
          if (sel_mounted) begin
            wr_d    = sel_wr;
            rd_d    = ~sel_wr;
            state_d = ISSUE;
          end else begin
            // No image: answer locally with a two-cycle ack (here + FINISH).
            ack_d   = gnt_1h;
            synth_d = 1'b1;
            state_d = FINISH;
          end
        end
      end
      ISSUE: begin
        if (wd_fire) begin
          timeout_d = 1'b1;
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          ack_d     = own_1h;
          state_d   = FINISH;
        end else if (sd_ack) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          ack_d   = own_1h;
          state_d = XFER;
        end
      end
      XFER: begin
        if (wd_fire) begin
          timeout_d = 1'b1;
          ack_d     = own_1h;
          state_d   = FINISH;
        end else if (sd_ack) begin
          ack_d = own_1h;
        end else begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        if (synth_q) begin
          ack_d = own_1h;
        end else begin
          active_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d != state_q) begin
      wd_d = '0;
    end else if ((state_q == ISSUE) || (state_q == XFER)) begin
      wd_d = wd_q + 1'b1;
    end else begin
      wd_d = '0;
    end
  end

  // State, command, strobe and watchdog registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      lba_q     <= '0;
      blk_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      ack_q     <= '0;
      active_q  <= 1'b0;
      timeout_q <= 1'b0;
      synth_q   <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      lba_q     <= lba_d;
      blk_q     <= blk_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      ack_q     <= ack_d;
      active_q  <= active_d;
      timeout_q <= timeout_d;
      synth_q   <= synth_d;
      wd_q      <= wd_d;
    end
  end

  assign req_ack    = ack_q;
  assign sd_lba     = lba_q;
  assign sd_blk_cnt = blk_q;
  assign sd_rd      = rd_q;
  assign sd_wr      = wr_q;
  assign owner      = owner_q;
  assign active     = active_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_ieeedrv_sd_arb.sv
// Self-checking bench for ieeedrv_sd_arb: a main instance with the default
// watchdog and a second instance with a 4-bit watchdog for the abort path.
module tb_ieeedrv_sd_arb;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        reset_n;
  logic [1:0]  mounted;
  logic [63:0] req_lba;
  logic [11:0] req_blk_cnt;
  logic [1:0]  req_rd, req_wr, req_ack;
  logic [31:0] sd_lba;
  logic [5:0]  sd_blk_cnt;
  logic        sd_rd, sd_wr, sd_ack;
  logic        owner, active, timeout;

  logic        w_reset_n;
  logic [1:0]  w_mounted;
  logic [63:0] w_req_lba;
  logic [11:0] w_req_blk_cnt;
  logic [1:0]  w_req_rd, w_req_wr, w_req_ack;
  logic [31:0] w_sd_lba;
  logic [5:0]  w_sd_blk_cnt;
  logic        w_sd_rd, w_sd_wr, w_sd_ack;
  logic        w_owner, w_active, w_timeout;

  ieeedrv_sd_arb #(.SUBDRV(2), .TIMEOUT_W(24)) u_dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .mounted(mounted),
    .req_lba(req_lba), .req_blk_cnt(req_blk_cnt), .req_rd(req_rd), .req_wr(req_wr),
    .req_ack(req_ack), .sd_lba(sd_lba), .sd_blk_cnt(sd_blk_cnt), .sd_rd(sd_rd),
    .sd_wr(sd_wr), .sd_ack(sd_ack), .owner(owner), .active(active), .timeout(timeout)
  );

  ieeedrv_sd_arb #(.SUBDRV(2), .TIMEOUT_W(4)) u_dut_wd (
    .clk_sys(clk_sys), .reset_n(w_reset_n), .mounted(w_mounted),
    .req_lba(w_req_lba), .req_blk_cnt(w_req_blk_cnt), .req_rd(w_req_rd), .req_wr(w_req_wr),
    .req_ack(w_req_ack), .sd_lba(w_sd_lba), .sd_blk_cnt(w_sd_blk_cnt), .sd_rd(w_sd_rd),
    .sd_wr(w_sd_wr), .sd_ack(w_sd_ack), .owner(w_owner), .active(w_active), .timeout(w_timeout)
  );

  typedef struct {
    logic        own;
    logic [31:0] lba;
    logic [5:0]  blk;
    logic        wr;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned passed = 0;

  task automatic set_req(input int d, input logic rd, input logic wr,
                         input logic [31:0] lba, input logic [5:0] blk);
    req_rd[d]               = rd;
    req_wr[d]               = wr;
    req_lba[d*32 +: 32]     = lba;
    req_blk_cnt[d*6 +: 6]   = blk;
  endtask

  // Host + requester model: wait for a strobe, snapshot the command, ack it
  // for ack_len cycles (requester withdraws on its ack), wait for idle.
  task automatic host_txn(input int ack_len, output bit got,
                          output logic [31:0] lba, output logic [5:0] blk,
                          output logic own, output logic rd, output logic wr);
    got = 1'b0; lba = '0; blk = '0; own = 1'b0; rd = 1'b0; wr = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_sys);
      if (sd_rd || sd_wr) begin
        got = 1'b1;
        lba = sd_lba; blk = sd_blk_cnt; own = owner; rd = sd_rd; wr = sd_wr;
      end
    end
    if (got) begin
      sd_ack = 1'b1;
      repeat (ack_len) @(negedge clk_sys);
      req_rd[own] = 1'b0;
      req_wr[own] = 1'b0;
      sd_ack = 1'b0;
      for (int i = 0; i < 10 && active; i++) @(negedge clk_sys);
    end
  endtask

  task automatic test_reset();
    int bad;
    reset_n = 1'b0; mounted = '0; req_lba = '0; req_blk_cnt = '0;
    req_rd = '0; req_wr = '0; sd_ack = 1'b0;
    w_reset_n = 1'b0; w_mounted = '0; w_req_lba = '0; w_req_blk_cnt = '0;
    w_req_rd = '0; w_req_wr = '0; w_sd_ack = 1'b0;
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({req_ack, sd_rd, sd_wr, owner, active, timeout} !== 7'd0)
      $display("FAIL reset_ctrl: got %b expected 0000000", {req_ack, sd_rd, sd_wr, owner, active, timeout});
    else passed++;
    checks++;
    if ({sd_lba, sd_blk_cnt} !== 38'd0)
      $display("FAIL reset_cmd: got %h expected 0", {sd_lba, sd_blk_cnt});
    else passed++;
    checks++;
    if ({w_req_ack, w_sd_rd, w_sd_wr, w_owner, w_active, w_timeout, w_sd_lba, w_sd_blk_cnt} !== 45'd0)
      $display("FAIL reset_wd_inst: got %h expected 0",
               {w_req_ack, w_sd_rd, w_sd_wr, w_owner, w_active, w_timeout, w_sd_lba, w_sd_blk_cnt});
    else passed++;
    reset_n = 1'b1; w_reset_n = 1'b1;
    // A host ack with no transaction in flight must not be routed.
    sd_ack = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk_sys);
      if (req_ack !== 2'b00 || active !== 1'b0) bad++;
    end
    sd_ack = 1'b0;
    checks++;
    if (bad !== 0) $display("FAIL late_ack_idle: got %0d bad cycles expected 0", bad);
    else passed++;
  endtask

  task automatic test_contention();
    exp_t e; bit got; logic [31:0] lba; logic [5:0] blk; logic own, rd, wr; int n;
    mounted = 2'b11;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk_sys);
      case (r)
        0: begin
          set_req(0, 1'b1, 1'b0, 32'd300, 6'd5);
          set_req(1, 1'b0, 1'b1, 32'd400, 6'd7);
          sb.push_back('{1'b0, 32'd300, 6'd5, 1'b0});
          sb.push_back('{1'b1, 32'd400, 6'd7, 1'b1});
        end
        1: begin
          set_req(0, 1'b1, 1'b1, 32'd500, 6'd9);
          sb.push_back('{1'b0, 32'd500, 6'd9, 1'b1});
        end
        default: begin
          set_req(0, 1'b1, 1'b0, 32'd600, 6'd10);
          set_req(1, 1'b1, 1'b0, 32'd700, 6'd11);
          sb.push_back('{1'b1, 32'd700, 6'd11, 1'b0});
          sb.push_back('{1'b0, 32'd600, 6'd10, 1'b0});
        end
      endcase
      n = 0;
      while (sb.size() > 0 && n < 4) begin
        host_txn(3, got, lba, blk, own, rd, wr);
        e = sb.pop_front();
        n++;
        checks++;
        if (!got)
          $display("FAIL contention_r%0d: no strobe, expected owner %0d", r, e.own);
        else if ({own, lba, blk, wr, rd} !== {e.own, e.lba, e.blk, e.wr, ~e.wr})
          $display("FAIL contention_r%0d: got %h expected %h", r,
                   {own, lba, blk, wr, rd}, {e.own, e.lba, e.blk, e.wr, ~e.wr});
        else passed++;
      end
    end
  endtask

  task automatic test_single_read();
    exp_t e; int hi, first, other, strobes, act_fall;
    @(negedge clk_sys);
    mounted = 2'b11;
    set_req(0, 1'b1, 1'b0, 32'd100, 6'd28);
    sb.push_back('{1'b0, 32'd100, 6'd28, 1'b0});
    @(negedge clk_sys);
    e = sb.pop_front();
    checks++;
    if ({sd_rd, sd_wr, owner, sd_lba, sd_blk_cnt, active} !== {1'b1, 1'b0, e.own, e.lba, e.blk, 1'b1})
      $display("FAIL single_grant: got %h expected %h", {sd_rd, sd_wr, owner, sd_lba, sd_blk_cnt, active},
               {1'b1, 1'b0, e.own, e.lba, e.blk, 1'b1});
    else passed++;
    req_rd[0] = 1'b0;  // requester withdraws before the host answers
    repeat (2) @(negedge clk_sys);
    checks++;
    if (sd_rd !== 1'b1) $display("FAIL single_hold: sd_rd got %b expected 1", sd_rd);
    else passed++;
    sd_ack = 1'b1;
    hi = 0; first = -1; other = 0; strobes = 0; act_fall = -1;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk_sys);
      if (req_ack[0]) begin hi++; if (first < 0) first = i; end
      if (req_ack[1]) other++;
      if (sd_rd || sd_wr) strobes++;
      if (!active && act_fall < 0) act_fall = i;
      if (i == 40) sd_ack = 1'b0;
    end
    checks++;
    if (hi !== 40 || first !== 1)
      $display("FAIL single_ack0: got %0d cycles from %0d expected 40 from 1", hi, first);
    else passed++;
    checks++;
    if (other !== 0 || strobes !== 0)
      $display("FAIL single_others: got ack1=%0d strobes=%0d expected 0 0", other, strobes);
    else passed++;
    checks++;
    if (act_fall !== 42) $display("FAIL single_active_fall: got %0d expected 42", act_fall);
    else passed++;
  endtask

  task automatic test_unmounted();
    int strobes, ack1, first, ack0, act3, own1;
    @(negedge clk_sys);
    mounted = 2'b01;
    set_req(1, 1'b1, 1'b0, 32'd55, 6'd1);
    strobes = 0; ack1 = 0; first = -1; ack0 = 0; act3 = -1; own1 = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk_sys);
      if (sd_rd || sd_wr) strobes++;
      if (req_ack[0]) ack0++;
      if (req_ack[1]) begin ack1++; if (first < 0) first = i; req_rd[1] = 1'b0; end
      if (i == 1) own1 = int'(owner);
      if (i == 3) act3 = int'(active);
    end
    checks++;
    if (strobes !== 0) $display("FAIL unmounted_strobe: got %0d expected 0", strobes);
    else passed++;
    checks++;
    if (ack1 !== 2 || first !== 1 || ack0 !== 0)
      $display("FAIL unmounted_ack: got %0d from %0d (ack0 %0d) expected 2 from 1 (ack0 0)", ack1, first, ack0);
    else passed++;
    checks++;
    if (own1 !== 1 || act3 !== 0)
      $display("FAIL unmounted_state: got owner=%0d active=%0d expected 1 0", own1, act3);
    else passed++;
    mounted = 2'b11;
  endtask

  task automatic test_timeout();
    int rd_cnt, rd_first, wr_cnt, to_cnt, to_at, ack_cnt, ack_at, ack1, fall;
    logic [38:0] snap;
    @(negedge clk_sys);
    w_mounted = 2'b11;
    w_req_lba[31:0] = 32'h0000_1234;
    w_req_blk_cnt[5:0] = 6'd3;
    w_req_rd[0] = 1'b1;
    rd_cnt = 0; rd_first = -1; wr_cnt = 0; to_cnt = 0; to_at = -1;
    ack_cnt = 0; ack_at = -1; ack1 = 0; fall = -1; snap = '0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk_sys);
      if (w_sd_rd) begin rd_cnt++; if (rd_first < 0) rd_first = i; end
      if (w_sd_wr) wr_cnt++;
      if (w_timeout) begin to_cnt++; to_at = i; end
      if (w_req_ack[0]) begin ack_cnt++; ack_at = i; w_req_rd[0] = 1'b0; end
      if (w_req_ack[1]) ack1++;
      if (!w_active && fall < 0) fall = i;
      if (i == 1) snap = {w_owner, w_sd_lba, w_sd_blk_cnt};
    end
    checks++;
    if (snap !== {1'b0, 32'h0000_1234, 6'd3})
      $display("FAIL timeout_cmd: got %h expected %h", snap, {1'b0, 32'h0000_1234, 6'd3});
    else passed++;
    // Watchdog counts 0..15 across 16 ISSUE cycles, then aborts.
    checks++;
    if (rd_cnt !== 16 || rd_first !== 1 || wr_cnt !== 0)
      $display("FAIL timeout_strobe: got rd %0d from %0d wr %0d expected 16 from 1 wr 0", rd_cnt, rd_first, wr_cnt);
    else passed++;
    checks++;
    if (to_cnt !== 1 || to_at !== 17)
      $display("FAIL timeout_pulse: got %0d at %0d expected 1 at 17", to_cnt, to_at);
    else passed++;
    checks++;
    if (ack_cnt !== 1 || ack_at !== 17 || ack1 !== 0)
      $display("FAIL timeout_ack: got %0d at %0d (ack1 %0d) expected 1 at 17 (ack1 0)", ack_cnt, ack_at, ack1);
    else passed++;
    checks++;
    if (fall !== 18) $display("FAIL timeout_idle: active fell at %0d expected 18", fall);
    else passed++;
  endtask

  task automatic test_reset_mid_xfer();
    int bad;
    @(negedge clk_sys);
    set_req(0, 1'b1, 1'b0, 32'd77, 6'd2);
    @(negedge clk_sys);
    req_rd[0] = 1'b0;
    sd_ack = 1'b1;
    @(negedge clk_sys);
    checks++;
    if ({req_ack, active} !== 3'b011) $display("FAIL rst_xfer_pre: got %b expected 011", {req_ack, active});
    else passed++;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({req_ack, sd_rd, sd_wr, owner, active, timeout, sd_lba, sd_blk_cnt} !== 45'd0)
      $display("FAIL rst_xfer_async: got %h expected 0",
               {req_ack, sd_rd, sd_wr, owner, active, timeout, sd_lba, sd_blk_cnt});
    else passed++;
    @(negedge clk_sys);
    reset_n = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk_sys);
      if (req_ack !== 2'b00 || active !== 1'b0 || sd_rd || sd_wr) bad++;
    end
    sd_ack = 1'b0;
    checks++;
    if (bad !== 0) $display("FAIL rst_xfer_release: got %0d bad cycles expected 0", bad);
    else passed++;
  endtask

  task automatic test_stability();
    exp_t e; int bad;
    @(negedge clk_sys);
    set_req(0, 1'b1, 1'b0, 32'd100, 6'd3);
    sb.push_back('{1'b0, 32'd100, 6'd3, 1'b0});
    @(negedge clk_sys);
    e = sb.pop_front();
    checks++;
    if ({sd_rd, owner, sd_lba, sd_blk_cnt} !== {1'b1, e.own, e.lba, e.blk})
      $display("FAIL stable_grant: got %h expected %h", {sd_rd, owner, sd_lba, sd_blk_cnt}, {1'b1, e.own, e.lba, e.blk});
    else passed++;
    req_lba[31:0] = 32'd200;
    req_blk_cnt[5:0] = 6'd40;
    bad = 0;
    repeat (3) begin
      @(negedge clk_sys);
      if (sd_lba !== e.lba || sd_blk_cnt !== e.blk) bad++;
    end
    sd_ack = 1'b1;
    repeat (3) begin
      @(negedge clk_sys);
      if (sd_lba !== e.lba || sd_blk_cnt !== e.blk) bad++;
    end
    req_rd[0] = 1'b0;
    sd_ack = 1'b0;
    for (int i = 0; i < 6 && active; i++) begin
      @(negedge clk_sys);
      if (active && (sd_lba !== e.lba || sd_blk_cnt !== e.blk)) bad++;
    end
    if (active) bad++;
    checks++;
    if (bad !== 0) $display("FAIL stable_cmd: got %0d bad cycles expected 0", bad);
    else passed++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_contention();
    test_single_read();
    test_unmounted();
    test_timeout();
    test_reset_mid_xfer();
    test_stability();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
